// File: rtl/lane_mux_scheduler.sv
// Merges four byte lanes onto one 8-bit clk_4f stream: SYNC preamble after enable, then round-robin
// grants (fixed TDM slots when LANE_MUX_TDM_SLOT_EN is defined), IDLE fill when no lane is granted.
module lane_mux_scheduler #(
  parameter int unsigned NLANES    = 4,
  parameter int unsigned SYNC_LEN  = 4,
  parameter logic [7:0]  COM_CHAR  = 8'hBC,
  parameter logic [7:0]  IDLE_CHAR = 8'h7C
) (
  input  logic                  clk_4f,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [8*NLANES-1:0]   data_in,
  input  logic [NLANES-1:0]     valid_in,
  output logic [NLANES-1:0]     ready_out,
  output logic [7:0]            data_out,
  output logic                  valid_out,
  output logic [1:0]            lane_id,
  output logic [1:0]            state_out
);

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SYNC   = 2'b01,
    ACTIVE = 2'b10
  } state_t;

  state_t              state, state_nxt;
  logic [3:0]          sync_cnt, sync_cnt_nxt;
  logic [NLANES-1:0]   grant;
  logic [1:0]          gnt_idx;
  logic                gnt_vld;
  logic [7:0]          data_nxt;
  logic                valid_nxt;
  logic [1:0]          lane_nxt;
`ifdef LANE_MUX_TDM_SLOT_EN
  logic [1:0]          slot, slot_nxt;
`else
  logic [1:0]          ptr, ptr_nxt;
  logic [1:0]          cand;
`endif

  // Next-state, arbitration and output-register next values
  always_comb begin
    state_nxt    = state;
    sync_cnt_nxt = sync_cnt;
    grant        = '0;
    gnt_idx      = '0;
    gnt_vld      = 1'b0;
    data_nxt     = IDLE_CHAR;
    valid_nxt    = 1'b0;
    lane_nxt     = lane_id;
`ifdef LANE_MUX_TDM_SLOT_EN
    slot_nxt     = slot;
`else
    ptr_nxt      = ptr;
    cand         = '0;
`endif
    case (state)
      IDLE: begin
        lane_nxt = '0;
        if (enable) begin
          state_nxt    = SYNC;
          sync_cnt_nxt = '0;
        end
      end
      SYNC: begin
        lane_nxt = '0;
        if (!enable) begin
          state_nxt = IDLE;
        end else begin
          data_nxt     = COM_CHAR;
          valid_nxt    = 1'b1;
          sync_cnt_nxt = sync_cnt + 4'd1;
          if (sync_cnt == SYNC_LAST) begin
            state_nxt = ACTIVE;
`ifdef LANE_MUX_TDM_SLOT_EN
            slot_nxt  = '0;
`endif
          end
        end
      end
      ACTIVE: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else begin
`ifdef LANE_MUX_TDM_SLOT_EN
          gnt_idx  = slot;
          gnt_vld  = valid_in[slot];
          slot_nxt = slot + 2'd1;
`else
          // First valid lane at or after ptr wins
          for (int unsigned i = 0; i < NLANES; i++) begin
            cand = ptr + 2'(i);
            if (!gnt_vld && valid_in[cand]) begin
              gnt_vld = 1'b1;
              gnt_idx = cand;
            end
          end
          if (gnt_vld) ptr_nxt = gnt_idx + 2'd1;
`endif
          if (gnt_vld) begin
            grant[gnt_idx] = 1'b1;
            data_nxt       = data_in[{gnt_idx, 3'b000} +: 8];
            valid_nxt      = 1'b1;
            lane_nxt       = gnt_idx;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ready_out = reset ? '0 : grant;
  assign state_out = state;

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state     <= IDLE;
      sync_cnt  <= '0;
      data_out  <= IDLE_CHAR;
      valid_out <= 1'b0;
      lane_id   <= '0;
`ifdef LANE_MUX_TDM_SLOT_EN
      slot      <= '0;
`else
      ptr       <= '0;
`endif
    end else begin
      state     <= state_nxt;
      sync_cnt  <= sync_cnt_nxt;
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
      lane_id   <= lane_nxt;
`ifdef LANE_MUX_TDM_SLOT_EN
      slot      <= slot_nxt;
`else
      ptr       <= ptr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_lane_mux_scheduler.sv
// Scoreboard bench for lane_mux_scheduler: a lane-level reference model predicts grants and output
// bytes; a monitor pops expected bytes whenever valid_out is seen.
module tb_lane_mux_scheduler;

  localparam int unsigned SYNC_LEN = 4;

  logic        clk_4f = 1'b0;
  logic        reset  = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  valid_in = '0;
  logic [3:0]  ready_out;
  logic [7:0]  data_out;
  logic        valid_out;
  logic [1:0]  lane_id;
  logic [1:0]  state_out;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 sync, 2 active
  int m_mode = 0;
  int m_left = 0;
  int m_ptr  = 0;
  int m_slot = 0;
  logic [9:0] exp_q[$];

  lane_mux_scheduler #(.SYNC_LEN(SYNC_LEN)) dut (
    .clk_4f(clk_4f), .reset(reset), .enable(enable), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out), .lane_id(lane_id),
    .state_out(state_out)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle, compare combinational grant/state, then advance the model
  task automatic cycle(input logic rst, input logic en, input logic [3:0] v, input logic [31:0] d);
    logic [3:0] exp_g;
    int win;
    int lane;
    @(negedge clk_4f);
    reset = rst; enable = en; valid_in = v; data_in = d;
    #1;
    exp_g = '0;
    win = -1;
    if (!rst && m_mode == 2 && en) begin
`ifdef LANE_MUX_TDM_SLOT_EN
      if (v[m_slot]) win = m_slot;
`else
      for (int k = 0; k < 4; k++) begin
        lane = (m_ptr + k) % 4;
        if (win < 0 && v[lane]) win = lane;
      end
`endif
      if (win >= 0) exp_g[win] = 1'b1;
    end
    chk("ready_out", 32'(ready_out), 32'(exp_g));
    chk("state_out", 32'(state_out), 32'(m_mode));
    if (rst) begin
      m_mode = 0; m_ptr = 0; m_slot = 0;
    end else begin
      case (m_mode)
        0: if (en) begin m_mode = 1; m_left = SYNC_LEN; end
        1: if (!en) m_mode = 0;
           else begin
             exp_q.push_back({2'd0, 8'hBC});
             m_left--;
             if (m_left == 0) begin m_mode = 2; m_slot = 0; end
           end
        default: if (!en) m_mode = 0;
           else begin
             m_slot = (m_slot + 1) % 4;
             if (win >= 0) begin
               m_ptr = (win + 1) % 4;
               exp_q.push_back({2'(win), d[8*win +: 8]});
             end
           end
      endcase
    end
  endtask

  // Monitor: every valid output byte must match the head of the scoreboard
  initial begin
    logic [9:0] e;
    forever begin
      @(posedge clk_4f);
      #1;
      if (valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=%0h required=none t=%0t", data_out, $time);
        end else begin
          e = exp_q.pop_front();
          chk("data_out", 32'(data_out), 32'(e[7:0]));
          chk("lane_id", 32'(lane_id), 32'(e[9:8]));
        end
      end else begin
        chk("idle_out", 32'({valid_out, data_out}), 32'({1'b0, 8'h7C}));
      end
    end
  end

  initial begin
    logic [3:0] rv;
    logic       ren;
    logic       rrst;
    repeat (3) cycle(1'b1, 1'b0, 4'h0, 32'h0);
    cycle(1'b0, 1'b0, 4'h0, 32'h0);
    chk("rst_lane_id", 32'(lane_id), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'h7C);
    // Enable and SYNC preamble
    repeat (SYNC_LEN + 1) cycle(1'b0, 1'b1, 4'h0, 32'h0);
    // All lanes valid
    repeat (6) cycle(1'b0, 1'b1, 4'hF, 32'h44332211);
    // Lanes 1 and 3 only
    repeat (4) cycle(1'b0, 1'b1, 4'b1010, 32'hCC00AA00);
    // Idle gap, then lane 2 alone
    repeat (2) cycle(1'b0, 1'b1, 4'h0, 32'h0);
    cycle(1'b0, 1'b1, 4'b0100, 32'h005A0000);
    cycle(1'b0, 1'b1, 4'h0, 32'h0);
    // Reset mid-ACTIVE with lanes valid, then re-enable
    repeat (2) cycle(1'b0, 1'b1, 4'hF, 32'hD4C3B2A1);
    cycle(1'b1, 1'b1, 4'hF, 32'hD4C3B2A1);
    repeat (SYNC_LEN + 6) cycle(1'b0, 1'b1, 4'hF, 32'h84736251);
    // enable drop mid-SYNC and mid-ACTIVE
    cycle(1'b0, 1'b0, 4'hF, 32'h0);
    repeat (2) cycle(1'b0, 1'b1, 4'hF, 32'h0);
    cycle(1'b0, 1'b0, 4'hF, 32'h0);
    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      rv   = 4'($urandom_range(0, 15));
      ren  = ($urandom_range(0, 29) != 0);
      rrst = ($urandom_range(0, 149) == 0);
      cycle(rrst, ren, rv, $urandom);
    end
    repeat (3) cycle(1'b0, 1'b0, 4'h0, 32'h0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
